// File: rtl/alu_acc_seq.sv
// Accumulator sequencer around a combinational 32-bit arithmetic unit: takes commands over a
// valid/ready handshake, runs one unit operation per command and returns the result plus flags.
module alu_acc_seq #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [W-1:0]     cmd_operand_i,
    output logic [W-1:0]     alu_a_o,
    output logic [W-1:0]     alu_b_o,
    output logic [1:0]       alu_f_o,
    input  logic [W-1:0]     alu_s_i,
    input  logic             alu_cout_i,
    input  logic             alu_ovf_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [W-1:0]     res_data_o,
    output logic             res_c_o,
    output logic             res_v_o,
    output logic             res_z_o,
    output logic             res_n_o,
    output logic             res_err_o,
    output logic             sticky_v_o,
    output logic [CNT_W-1:0] op_count_o
);

    localparam logic [2:0] OpLoad = 3'b000;
    localparam logic [2:0] OpAdd  = 3'b001;
    localparam logic [2:0] OpSub  = 3'b010;
    localparam logic [2:0] OpAinv = 3'b011;
    localparam logic [2:0] OpInc  = 3'b100;
    localparam logic [2:0] OpClrf = 3'b101;

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [W-1:0]     opnd_q, opnd_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            op_q     <= OpLoad;
            opnd_q   <= '0;
            acc_q    <= '0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            c_q      <= c_d;
            v_q      <= v_d;
            z_q      <= z_d;
            n_q      <= n_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        c_d      = c_q;
        v_d      = v_q;
        z_d      = z_q;
        n_d      = n_q;
        err_d    = err_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (cmd_valid_i) begin
                    op_d    = cmd_op_i;
                    opnd_d  = cmd_operand_i;
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
                case (op_q)
                    OpAdd, OpSub, OpAinv, OpInc: begin
                        acc_d    = alu_s_i;
                        c_d      = alu_cout_i;
                        v_d      = alu_ovf_i;
                        z_d      = (alu_s_i == '0);
                        n_d      = alu_s_i[W-1];
                        sticky_d = sticky_q | alu_ovf_i;
                        cnt_d    = cnt_q + CNT_W'(1);
                        err_d    = 1'b0;
                    end
                    OpLoad: begin
                        acc_d = opnd_q;
                        c_d   = 1'b0;
                        v_d   = 1'b0;
                        z_d   = (opnd_q == '0);
                        n_d   = opnd_q[W-1];
                        err_d = 1'b0;
                    end
                    OpClrf: begin
                        sticky_d = 1'b0;
                        err_d    = 1'b0;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            StResp: begin
                if (res_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Function select is only meaningful while executing; elsewhere the unit idles on "sum".
    always_comb begin
        alu_f_o = 2'b00;
        if (state_q == StExec) begin
            case (op_q)
                OpSub:   alu_f_o = 2'b01;
                OpAinv:  alu_f_o = 2'b10;
                OpInc:   alu_f_o = 2'b11;
                default: alu_f_o = 2'b00;
            endcase
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign res_valid_o = (state_q == StResp);
    assign alu_a_o     = acc_q;
    assign alu_b_o     = opnd_q;
    assign res_data_o  = acc_q;
    assign res_c_o     = c_q;
    assign res_v_o     = v_q;
    assign res_z_o     = z_q;
    assign res_n_o     = n_q;
    assign res_err_o   = err_q;
    assign sticky_v_o  = sticky_q;
    assign op_count_o  = cnt_q;

endmodule

// File: tb/tb_alu_acc_seq.sv
// Bench for alu_acc_seq: includes a behavioural arithmetic unit, a command-level model checked
// every cycle, and directed commands with hand-computed expectations.
module tb_alu_acc_seq;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [2:0]  cmd_op_i = 3'b000;
    logic [31:0] cmd_operand_i = 32'h0;
    logic [31:0] alu_a_o, alu_b_o;
    logic [1:0]  alu_f_o;
    logic [31:0] alu_s_i;
    logic        alu_cout_i, alu_ovf_i;
    logic        res_valid_o;
    logic        res_ready_i = 1'b0;
    logic [31:0] res_data_o;
    logic        res_c_o, res_v_o, res_z_o, res_n_o, res_err_o, sticky_v_o;
    logic [15:0] op_count_o;

    int n_total = 0;
    int n_pass  = 0;

    alu_acc_seq #(.W(32), .CNT_W(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_operand_i(cmd_operand_i),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_f_o(alu_f_o),
        .alu_s_i(alu_s_i), .alu_cout_i(alu_cout_i), .alu_ovf_i(alu_ovf_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_data_o(res_data_o), .res_c_o(res_c_o), .res_v_o(res_v_o),
        .res_z_o(res_z_o), .res_n_o(res_n_o), .res_err_o(res_err_o),
        .sticky_v_o(sticky_v_o), .op_count_o(op_count_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational arithmetic unit feeding the DUT.
    always_comb begin
        logic [32:0] t;
        t          = 33'h0;
        alu_s_i    = 32'h0;
        alu_cout_i = 1'b0;
        alu_ovf_i  = 1'b0;
        case (alu_f_o)
            2'b00: begin
                t = {1'b0, alu_a_o} + {1'b0, alu_b_o};
                alu_s_i = t[31:0]; alu_cout_i = t[32];
                alu_ovf_i = (alu_a_o[31] == alu_b_o[31]) && (t[31] != alu_a_o[31]);
            end
            2'b01: begin
                t = {1'b0, alu_a_o} + {1'b0, ~alu_b_o} + 33'd1;
                alu_s_i = t[31:0]; alu_cout_i = t[32];
                alu_ovf_i = (alu_a_o[31] != alu_b_o[31]) && (t[31] != alu_a_o[31]);
            end
            2'b10: alu_s_i = ~alu_a_o;
            default: begin
                t = {1'b0, alu_a_o} + 33'd1;
                alu_s_i = t[31:0]; alu_cout_i = t[32];
                alu_ovf_i = !alu_a_o[31] && t[31];
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Command-level model: results computed from the command's arithmetic meaning.
    typedef struct packed {
        logic [31:0] acc;
        logic        c, v, z, n, err, sticky;
        logic [15:0] cnt;
    } mstate_t;

    function automatic mstate_t model_exec(input logic [2:0] op, input logic [31:0] d,
                                           input mstate_t cur);
        mstate_t r;
        longint  sa, sb, ss;
        r  = cur;
        sa = longint'($signed(cur.acc));
        sb = longint'($signed(d));
        case (op)
            3'd0: begin
                r.acc = d; r.c = 1'b0; r.v = 1'b0;
            end
            3'd1: begin
                ss = sa + sb;
                r.acc = cur.acc + d;
                r.c = (64'(cur.acc) + 64'(d)) >= 64'h1_0000_0000;
                r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd2: begin
                ss = sa - sb;
                r.acc = cur.acc - d;
                r.c = (cur.acc >= d);
                r.v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            3'd3: begin
                r.acc = ~cur.acc; r.c = 1'b0; r.v = 1'b0;
            end
            3'd4: begin
                r.acc = cur.acc + 32'd1;
                r.c = (cur.acc == 32'hFFFF_FFFF);
                r.v = (cur.acc == 32'h7FFF_FFFF);
            end
            default: ;
        endcase
        if (op <= 3'd4) begin
            r.z = (r.acc == 32'h0);
            r.n = r.acc[31];
            r.err = 1'b0;
        end
        if (op >= 3'd1 && op <= 3'd4) begin
            r.sticky = cur.sticky | r.v;
            r.cnt = cur.cnt + 16'd1;
        end
        if (op == 3'd5) begin
            r.sticky = 1'b0;
            r.err = 1'b0;
        end
        if (op >= 3'd6) r.err = 1'b1;
        return r;
    endfunction

    function automatic logic [1:0] f_of(input logic [2:0] op);
        case (op)
            3'd2:    return 2'b01;
            3'd3:    return 2'b10;
            3'd4:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    mstate_t     m;
    logic [2:0]  m_op;
    logic [31:0] m_opnd;
    int          m_phase;  // 0 waiting for command, 1 executing, 2 holding result

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m       <= '0;
            m_op    <= 3'd0;
            m_opnd  <= 32'h0;
            m_phase <= 0;
        end else begin
            case (m_phase)
                0: if (cmd_valid_i) begin
                    m_op    <= cmd_op_i;
                    m_opnd  <= cmd_operand_i;
                    m_phase <= 1;
                end
                1: begin
                    m       <= model_exec(m_op, m_opnd, m);
                    m_phase <= 2;
                end
                default: if (res_ready_i) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("cmd_ready", 32'(cmd_ready_o), 32'(m_phase == 0));
            check("res_valid", 32'(res_valid_o), 32'(m_phase == 2));
            check("alu_a", alu_a_o, m.acc);
            check("alu_b", alu_b_o, m_opnd);
            check("alu_f", 32'(alu_f_o), 32'(m_phase == 1 ? f_of(m_op) : 2'b00));
            check("op_count", 32'(op_count_o), 32'(m.cnt));
            check("sticky_v", 32'(sticky_v_o), 32'(m.sticky));
            if (res_valid_o) begin
                check("res_data", res_data_o, m.acc);
                check("res_cvzn", {28'h0, res_c_o, res_v_o, res_z_o, res_n_o},
                      {28'h0, m.c, m.v, m.z, m.n});
                check("res_err", 32'(res_err_o), 32'(m.err));
            end
        end
    end

    // Called at a negedge; returns at a negedge with the result presented.
    task automatic send(input logic [2:0] op, input logic [31:0] d);
        int n;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_operand_i = d;
        n = 0;
        while (!cmd_ready_o && n < 20) begin @(negedge clk_i); n++; end
        if (n >= 20) begin n_total++; $display("FAIL accept_timeout: got none, expected accept"); end
        @(posedge clk_i); #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        n = 0;
        while (!res_valid_o && n < 20) begin @(negedge clk_i); n++; end
        if (n >= 20) begin n_total++; $display("FAIL result_timeout: got none, expected result"); end
    endtask

    task automatic take();
        res_ready_i = 1'b1;
        @(posedge clk_i); #1 res_ready_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic lit_flags(input string name, input logic [31:0] data, input logic [3:0] cvzn,
                             input logic [15:0] cnt);
        check({name, "_data"}, res_data_o, data);
        check({name, "_cvzn"}, {28'h0, res_c_o, res_v_o, res_z_o, res_n_o}, {28'h0, cvzn});
        check({name, "_cnt"}, 32'(op_count_o), 32'(cnt));
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        check("rst_res_valid", 32'(res_valid_o), 32'd0);
        check("rst_alu_ab", alu_a_o | alu_b_o, 32'h0);
        check("rst_alu_f", 32'(alu_f_o), 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);

        send(3'd0, 32'd6); take();
        send(3'd2, 32'd6);
        lit_flags("sub_eq", 32'h0, 4'b1010, 16'd1);
        take();

        send(3'd0, 32'h7FFF_FFFF); take();
        send(3'd1, 32'd1);
        lit_flags("add_ovf", 32'h8000_0000, 4'b0101, 16'd2);
        check("add_ovf_sticky", 32'(sticky_v_o), 32'd1);
        take();
        send(3'd2, 32'd1);
        lit_flags("sub_ovf", 32'h7FFF_FFFF, 4'b1100, 16'd3);
        take();
        send(3'd5, 32'd0);
        lit_flags("clrf", 32'h7FFF_FFFF, 4'b1100, 16'd3);
        check("clrf_sticky", 32'(sticky_v_o), 32'd0);
        take();

        send(3'd0, 32'd0); take();
        send(3'd3, 32'd0);
        lit_flags("ainv", 32'hFFFF_FFFF, 4'b0001, 16'd4);
        take();
        send(3'd4, 32'd0);
        lit_flags("inc_wrap", 32'h0, 4'b1010, 16'd5);
        take();

        send(3'd0, 32'd5); take();
        send(3'd7, 32'd0);
        check("illegal_err", 32'(res_err_o), 32'd1);
        lit_flags("illegal", 32'd5, 4'b0000, 16'd5);
        take();
        send(3'd0, 32'd9);
        check("load_clears_err", 32'(res_err_o), 32'd0);
        take();

        send(3'd0, 32'h1234);
        cmd_valid_i = 1'b1; cmd_op_i = 3'd1; cmd_operand_i = 32'd1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_valid", 32'(res_valid_o), 32'd1);
            check("bp_data", res_data_o, 32'h1234);
            check("bp_ready", 32'(cmd_ready_o), 32'd0);
        end
        res_ready_i = 1'b1;
        @(posedge clk_i); #1 res_ready_i = 1'b0;
        @(negedge clk_i);
        check("bp_idle_ready", 32'(cmd_ready_o), 32'd1);
        @(posedge clk_i); #1 cmd_valid_i = 1'b0;
        @(negedge clk_i);
        check("bp_exec_ready", 32'(cmd_ready_o), 32'd0);
        for (int n = 0; n < 20 && !res_valid_o; n++) @(negedge clk_i);
        lit_flags("bp_add", 32'h1235, 4'b0000, 16'd6);
        take();

        cmd_valid_i = 1'b1; cmd_op_i = 3'd1; cmd_operand_i = 32'd5;
        @(posedge clk_i); #1 cmd_valid_i = 1'b0; rst_i = 1'b1;
        #1 check("rst_exec_valid", 32'(res_valid_o), 32'd0);
        @(posedge clk_i); #1 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_exec_acc", alu_a_o, 32'h0);
        check("rst_exec_cnt", 32'(op_count_o), 32'd0);
        check("rst_exec_rv", 32'(res_valid_o), 32'd0);
        check("rst_exec_ready", 32'(cmd_ready_o), 32'd1);
        repeat (3) @(negedge clk_i);
        check("rst_no_commit", alu_a_o, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_acc_seq.md
# alu_acc_seq

Accumulator sequencer wrapped around the 32-bit arithmetic unit. It accepts commands over a valid/ready handshake and drives the unit's operand and function inputs from registered state. It captures the unit's sum, carry-out and overflow into an accumulator and a flag register, then returns a result over a second valid/ready handshake. It sits directly upstream of the unit, feeding A/B/f, and directly downstream of it, consuming S/c_out/O.

## Interface
- W, 32, datapath width; must equal the arithmetic unit width.
- CNT_W, 16, width of completed-operation counter.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  000 LOAD, 001 ADD, 010 SUB, 011 AINV, 100 INC, 101 CLRF, 110/111 illegal.
- cmd_operand  in  W  operand for LOAD/ADD/SUB; ignored otherwise.
- alu_a  out  W  to unit A input (accumulator).
- alu_b  out  W  to unit B input (latched operand).
- alu_f  out  2  to unit f: 00 sum, 01 sub, 10 ainv, 11 inc.
- alu_s  in  W  unit result S.
- alu_cout  in  1  unit carry-out.
- alu_ovf  in  1  unit overflow O.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  W  accumulator value after the command.
- res_c, res_v, res_z, res_n  out  1 each  carry, overflow, zero, negative flags of the last command.
- res_err  out  1  last command was illegal.
- sticky_v  out  1  OR of res_v since reset or last CLRF.
- op_count  out  CNT_W  number of completed ALU commands (ADD/SUB/AINV/INC).

## Operation
- States: IDLE, EXEC, RESP. Reset state IDLE.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_op into op_r and cmd_operand into opnd_r, then go to EXEC.
- EXEC: one cycle, cmd_ready=0. alu_a=acc, alu_b=opnd_r, alu_f from op_r (ADD→00, SUB→01, AINV→10, INC→11; LOAD/CLRF/illegal→00). At the end of the cycle, commit by op and go to RESP:
  - ADD/SUB/AINV/INC: acc←alu_s; C←alu_cout; V←alu_ovf; Z←(alu_s==0); N←alu_s[W-1]; sticky_v|=alu_ovf; op_count+1, wrapping at 2^CNT_W; err←0.
  - LOAD: acc←opnd_r; C←0, V←0; Z/N from opnd_r; err←0; unit outputs ignored.
  - CLRF: sticky_v←0; acc and C/V/Z/N unchanged; err←0.
  - Illegal: acc, flags, sticky_v and op_count unchanged; err←1.
- RESP: res_valid=1. res_data=acc, and flag outputs stay stable until the handshake. On res_ready, go to IDLE. cmd_ready stays 0 throughout RESP.
- Outside EXEC, alu_a/alu_b still drive acc/opnd_r and alu_f=00. The unit's output is don't-care there.
- Carry is passed through raw: on SUB, C=1 means no borrow (A≥B unsigned).

## Timing
- Reset values: acc=0, opnd_r=0, op_r=LOAD, C/V/Z/N=0, err=0, sticky_v=0, op_count=0, state IDLE. This gives cmd_ready=1, res_valid=0, alu_a=0, alu_b=0, alu_f=00.
- rst asserted in any state aborts immediately. An in-flight command is discarded with no commit. A pending result is dropped and res_valid falls asynchronously.
- Commands presented while rst=1 are not accepted.
- Latency: accept at edge E0 → EXEC during cycle E0..E1 → res_valid high after E1. Minimum 3 cycles per command; next accept earliest one edge after the result handshake.
- res_valid, once high, never drops without res_ready, except on reset.
- The unit is combinational and must settle within one clk period. No multicycle path.

## Test plan
- LOAD 6; SUB 6 → res_data=0, C=1, Z=1, V=0, N=0, op_count=1.
- LOAD 0x7FFFFFFF; ADD 1 → res_data=0x80000000, V=1, N=1, C=0, sticky_v=1. Then SUB 1 → 0x7FFFFFFF, V=1. Then CLRF → sticky_v=0, res_data=0x7FFFFFFF, V still 1.
- LOAD 0; AINV → 0xFFFFFFFF, N=1. Then INC → 0, C=1, Z=1.
- Backpressure: hold res_ready=0 for 5 cycles after a result → res_valid=1 with res_data and flags stable, cmd_ready=0. A cmd_valid held during this time is accepted only in the first IDLE cycle after the handshake.
- Illegal op 111 after LOAD 5 → res_err=1, res_data=5, op_count unchanged. A following LOAD clears res_err.
- Assert rst during EXEC of ADD → no commit; after release acc=0, op_count=0, res_valid=0, cmd_ready=1.
